// File: rtl/connect4_pkg.sv
// Shared types and defaults for the Connect 4 turn/drop sequencer.
package connect4_pkg;

    localparam int COLS_DEF        = 7;
    localparam int ROWS_DEF        = 6;
    localparam int CHK_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CHECK,
        SWAP,
        OVER
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/connect4_col_heights.sv
// Per-column fill heights: saturating counters with one read port and full flag.
module connect4_col_heights
    import connect4_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [2:0] inc_col,
    input  logic [2:0] rd_col,
    output logic [2:0] rd_height,
    output logic       rd_full
);

    localparam logic [2:0] ROWS_MAX = 3'(ROWS);

    logic [COLS-1:0][2:0] height_q;
    logic [COLS-1:0][2:0] height_d;

    always_comb begin
        height_d = height_q;
        for (int c = 0; c < COLS; c++) begin
            if (clr) begin
                height_d[c] = '0;
            end else if (inc && (inc_col == 3'(c)) && (height_q[c] < ROWS_MAX)) begin
                height_d[c] = height_q[c] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            height_q <= '0;
        end else begin
            height_q <= height_d;
        end
    end

    // An out-of-range column reads back as full so it can never be written.
    always_comb begin
        rd_height = ROWS_MAX;
        for (int c = 0; c < COLS; c++) begin
            if (rd_col == 3'(c)) begin
                rd_height = height_q[c];
            end
        end
        rd_full = (rd_height >= ROWS_MAX);
    end

endmodule

// File: rtl/connect4_turn_ctrl.sv
// Turn and drop sequencer: accepts legal drops, writes the board, runs the
// win-check handshake, then alternates players and re-centres the selector.
module connect4_turn_ctrl
    import connect4_pkg::*;
#(
    parameter int COLS        = COLS_DEF,
    parameter int ROWS        = ROWS_DEF,
    parameter int CHK_TIMEOUT = CHK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       drop,
    input  logic [2:0] colval,
    output logic       col_rst_n,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic       wr_player,
    output logic       chk_req,
    input  logic       chk_done,
    input  logic       chk_win,
    output logic       player,
    output logic       reject,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       chk_err,
    output logic [5:0] drop_count
);

    localparam logic [5:0]    CELLS    = 6'(ROWS * COLS);
    localparam int            TW       = $clog2(CHK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(CHK_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          drop_q;
    logic [2:0]    col_q, col_d;
    logic [2:0]    wr_row_q, wr_row_d;
    logic          player_q, player_d;
    logic [1:0]    winner_q, winner_d;
    logic          chk_err_q, chk_err_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          reject_q, reject_d;
    logic          col_rst_n_q, col_rst_n_d;
    logic          wr_en_q, chk_req_q, game_over_q;

    logic          drop_edge, col_ok, chk_fin;
    logic          hgt_inc, hgt_clr, rd_full;
    logic [2:0]    rd_height;

    assign drop_edge = drop & ~drop_q;
    assign col_ok    = int'(colval) < COLS;

    connect4_col_heights #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_heights (
        .clk       (clk),
        .rst       (rst),
        .clr       (hgt_clr),
        .inc       (hgt_inc),
        .inc_col   (col_q),
        .rd_col    (colval),
        .rd_height (rd_height),
        .rd_full   (rd_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        wr_row_d    = wr_row_q;
        player_d    = player_q;
        winner_d    = winner_q;
        chk_err_d   = chk_err_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        reject_d    = 1'b0;
        col_rst_n_d = 1'b1;
        hgt_inc     = 1'b0;
        hgt_clr     = 1'b0;
        chk_fin     = 1'b0;

        if (new_game) begin
            state_d     = IDLE;
            player_d    = 1'b0;
            winner_d    = WIN_NONE;
            chk_err_d   = 1'b0;
            cnt_d       = '0;
            tmo_d       = '0;
            hgt_clr     = 1'b1;
            col_rst_n_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (drop_edge) begin
                        if (col_ok && !rd_full) begin
                            col_d    = colval;
                            wr_row_d = rd_height;
                            state_d  = WRITE;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    hgt_inc = 1'b1;
                    if (cnt_q != CELLS) begin
                        cnt_d = cnt_q + 6'd1;
                    end
                    tmo_d   = '0;
                    state_d = CHECK;
                end
                CHECK: begin
                    tmo_d   = tmo_q + TW'(1);
                    chk_fin = chk_done || (tmo_q == TMO_LAST);
                    // A silent checker is flagged and the piece is treated as no-win.
                    if (!chk_done && (tmo_q == TMO_LAST)) begin
                        chk_err_d = 1'b1;
                    end
                    if (chk_fin) begin
                        if (chk_done && chk_win) begin
                            winner_d = player_q ? WIN_P2 : WIN_P1;
                            state_d  = OVER;
                        end else if (cnt_q == CELLS) begin
                            winner_d = WIN_DRAW;
                            state_d  = OVER;
                        end else begin
                            player_d    = ~player_q;
                            col_rst_n_d = 1'b0;
                            state_d     = SWAP;
                        end
                    end
                end
                SWAP:    state_d = IDLE;
                OVER:    state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state so every output comes off a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q      <= 1'b0;
            col_q       <= '0;
            wr_row_q    <= '0;
            player_q    <= 1'b0;
            winner_q    <= WIN_NONE;
            chk_err_q   <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            reject_q    <= 1'b0;
            col_rst_n_q <= 1'b0;
            wr_en_q     <= 1'b0;
            chk_req_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            drop_q      <= drop;
            col_q       <= col_d;
            wr_row_q    <= wr_row_d;
            player_q    <= player_d;
            winner_q    <= winner_d;
            chk_err_q   <= chk_err_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            reject_q    <= reject_d;
            col_rst_n_q <= col_rst_n_d;
            wr_en_q     <= (state_d == WRITE);
            chk_req_q   <= (state_d == CHECK);
            game_over_q <= (state_d == OVER);
        end
    end

    assign col_rst_n  = col_rst_n_q;
    assign wr_en      = wr_en_q;
    assign wr_row     = wr_row_q;
    assign wr_col     = col_q;
    assign wr_player  = player_q;
    assign chk_req    = chk_req_q;
    assign player     = player_q;
    assign reject     = reject_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign chk_err    = chk_err_q;
    assign drop_count = cnt_q;

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Scoreboard bench for connect4_turn_ctrl: board-level reference model,
// emulated win checker, and a monitor that pops expected writes/rejects.
module tb_connect4_turn_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_game;
    logic       drop;
    logic [2:0] colval;
    logic       col_rst_n, wr_en, wr_player, chk_req, chk_done, chk_win;
    logic [2:0] wr_row, wr_col;
    logic       player, reject, game_over, chk_err;
    logic [1:0] winner;
    logic [5:0] drop_count;

    connect4_turn_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .drop       (drop),
        .colval     (colval),
        .col_rst_n  (col_rst_n),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_player  (wr_player),
        .chk_req    (chk_req),
        .chk_done   (chk_done),
        .chk_win    (chk_win),
        .player     (player),
        .reject     (reject),
        .game_over  (game_over),
        .winner     (winner),
        .chk_err    (chk_err),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rej;
        int row;
        int col;
        int ply;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    // Reference board state
    int  m_h[7];
    int  m_ply, m_cnt, m_win, m_colrst;
    bit  m_over, m_err;

    // Checker emulation and pulse accounting
    bit  rsp_en, rsp_win, cnt_en;
    int  rsp_delay;
    int  req_cyc = 0;
    int  colrst_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic m_clear();
        foreach (m_h[i]) m_h[i] = 0;
        m_ply  = 0;
        m_cnt  = 0;
        m_win  = 0;
        m_over = 0;
        m_err  = 0;
    endtask

    task automatic settle_check();
        check("player", int'(player), m_ply);
        check("winner", int'(winner), m_win);
        check("game_over", int'(game_over), int'(m_over));
        check("drop_count", int'(drop_count), m_cnt);
        check("chk_err", int'(chk_err), int'(m_err));
        check("col_rst_pulses", colrst_seen, m_colrst);
    endtask

    task automatic check_rst_vals();
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_chk_req", int'(chk_req), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_chk_err", int'(chk_err), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_drop_count", int'(drop_count), 0);
        check("rst_col_rst_n", int'(col_rst_n), 0);
        check("rst_player", int'(player), 0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic do_drop(input int c, input bit win, input int dly);
        bit legal = 0;
        bit rej   = 0;
        int n;
        colval    = 3'(c);
        drop      = 1'b1;
        rsp_win   = win;
        rsp_delay = dly;
        if (m_over) begin
            legal = 0;
        end else if (c >= 7 || m_h[c] >= 6) begin
            rej = 1;
            exp_q.push_back('{1'b1, 0, 0, 0});
        end else begin
            legal = 1;
            exp_q.push_back('{1'b0, m_h[c], c, m_ply});
            m_h[c]++;
            m_cnt++;
            if (!rsp_en) m_err = 1;
            if (rsp_en && win) begin
                m_win  = m_ply + 1;
                m_over = 1;
            end else if (m_cnt == 42) begin
                m_win  = 3;
                m_over = 1;
            end else begin
                m_ply ^= 1;
                m_colrst++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        drop = 1'b0;
        check("wr_en_latency", int'(wr_en), int'(legal));
        check("reject_latency", int'(reject), int'(rej));
        if (legal) begin
            @(negedge clk);
            check("chk_req_latency", int'(chk_req), 1);
            n = 0;
            while (chk_req && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("chk_req_release", int'(chk_req), 0);
        end
        @(negedge clk);
        settle_check();
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(posedge clk);
        @(negedge clk);
        new_game = 1'b0;
        m_clear();
        m_colrst++;
        @(negedge clk);
        settle_check();
    endtask

    // Asserts rst between clock edges and checks outputs before the next edge.
    task automatic do_reset_mid();
        cnt_en = 0;
        #3;
        rst = 1'b1;
        #1;
        check_rst_vals();
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        cnt_en = 1;
        check("col_rst_n_after_rst", int'(col_rst_n), 1);
    endtask

    // Win checker: answers chk_req after rsp_delay cycles with a one-cycle done.
    initial begin
        chk_done = 1'b0;
        chk_win  = 1'b0;
        forever begin
            @(negedge clk);
            chk_done = 1'b0;
            chk_win  = 1'b0;
            if (chk_req && !rst) begin
                req_cyc++;
                if (rsp_en && req_cyc == rsp_delay) begin
                    chk_done = 1'b1;
                    chk_win  = rsp_win;
                end
            end else begin
                req_cyc = 0;
            end
        end
    end

    // Monitor: every write or reject pulse must match the head of the scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && (wr_en || reject)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'({wr_en, reject}), 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rej) begin
                        check("ev_reject", int'(reject), 1);
                        check("ev_no_write", int'(wr_en), 0);
                    end else begin
                        check("ev_wr_en", int'(wr_en), 1);
                        check("ev_wr_row", int'(wr_row), e.row);
                        check("ev_wr_col", int'(wr_col), e.col);
                        check("ev_wr_player", int'(wr_player), e.ply);
                    end
                end
            end
            if (cnt_en && !col_rst_n) colrst_seen++;
        end
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        new_game  = 1'b0;
        drop      = 1'b0;
        colval    = 3'd0;
        rsp_en    = 1;
        rsp_win   = 0;
        rsp_delay = 2;
        cnt_en    = 0;
        m_colrst  = 0;
        m_clear();
        repeat (3) @(negedge clk);
        check_rst_vals();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cnt_en = 1;
        check("col_rst_n_release", int'(col_rst_n), 1);

        // First drop, checker says no-win after 2 cycles
        do_drop(3, 0, 2);

        // Column 0 filled, seventh drop rejected
        do_new_game();
        for (int i = 0; i < 6; i++) do_drop(0, 0, 1 + i % 3);
        do_drop(0, 0, 2);
        // Out-of-range column
        do_drop(7, 0, 2);

        // P1 wins on its fourth piece; later drops are ignored
        do_new_game();
        for (int i = 0; i < 7; i++) do_drop(i % 2, i == 6, 2);
        check("p1_winner", int'(winner), 1);
        do_drop(2, 0, 2);
        do_new_game();
        do_drop(0, 0, 2);

        // Full board, no winner
        do_new_game();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++) do_drop(c, 0, 1);
        check("draw_winner", int'(winner), 3);
        check("draw_count", int'(drop_count), 42);

        // Checker never answers
        do_new_game();
        rsp_en = 0;
        do_drop(4, 0, 1);
        check("timeout_err", int'(chk_err), 1);
        rsp_en = 1;

        // Reset while waiting in CHECK
        do_new_game();
        rsp_en = 0;
        colval = 3'd5;
        drop   = 1'b1;
        exp_q.push_back('{1'b0, 0, 5, 0});
        @(negedge clk);
        drop = 1'b0;
        @(negedge clk);
        check("mid_chk_req", int'(chk_req), 1);
        repeat (3) @(negedge clk);
        do_reset_mid();
        rsp_en = 1;
        settle_check();

        // Random play
        for (int i = 0; i < 300; i++) begin
            if (m_over) begin
                if ($urandom_range(0, 1) == 1) do_drop(int'($urandom_range(0, 6)), 0, 1);
                do_new_game();
            end else begin
                int c;
                c = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, 6));
                do_drop(c, $urandom_range(0, 24) == 0, int'($urandom_range(1, 5)));
            end
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
